// File: rtl/s27_bist_ctrl.sv
// s27_bist_ctrl: BIST controller for the ISCAS-89 s27 benchmark circuit.
// Holds an init vector to settle the s27 flops, drives LFSR patterns onto
// G3..G0, compacts the G17 response into a 16-bit signature and flags done.
// Optional macro: S27_BIST_CMP_EN builds the signature comparator that drives PASS.
// Ports:
//   CK          clock, rising edge
//   RST         synchronous active-high reset
//   START       run request, honoured in IDLE and DONE only
//   G0..G3      registered stimulus to the s27 inputs
//   G17         s27 response input
//   BUSY        high during INIT and RUN
//   DONE        high in DONE
//   PASS        signature-match flag (constant 0 without the comparator)
//   SIG         signature register
module s27_bist_ctrl #(
  parameter int unsigned N_PATTERNS  = 255,
  parameter int unsigned INIT_CYCLES = 2,
  parameter logic [3:0]  INIT_VEC    = 4'b1100,
  parameter logic [7:0]  SEED        = 8'h01,
  parameter logic [15:0] EXP_SIG     = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        START,
  output logic        G0,
  output logic        G1,
  output logic        G2,
  output logic        G3,
  input  logic        G17,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] SIG
);

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned SIG_W  = 16;
  localparam int unsigned PAT_W  = 16;
  localparam int unsigned INIT_W = 8;
  localparam int unsigned VEC_W  = 4;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(N_PATTERNS - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [SIG_W-1:0]  CRC_POLY  = 16'h1021;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [LFSR_W-1:0]  lfsr, lfsr_nxt, lfsr_adv;
  logic [SIG_W-1:0]   sig_q, sig_nxt, sig_upd;
  logic [PAT_W-1:0]   pat_cnt, pat_cnt_nxt;
  logic [INIT_W-1:0]  init_cnt, init_cnt_nxt;
  logic [VEC_W-1:0]   vec_q, vec_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
`ifdef S27_BIST_CMP_EN
  logic               pass_q, pass_nxt;
`endif

  // State and datapath registers; reset forces IDLE with a reseeded LFSR.
  always_ff @(posedge CK) begin
    if (RST) begin
      state    <= S_IDLE;
      lfsr     <= SEED_EFF;
      sig_q    <= '0;
      pat_cnt  <= '0;
      init_cnt <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef S27_BIST_CMP_EN
      pass_q   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      lfsr     <= lfsr_nxt;
      sig_q    <= sig_nxt;
      pat_cnt  <= pat_cnt_nxt;
      init_cnt <= init_cnt_nxt;
      vec_q    <= vec_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
`ifdef S27_BIST_CMP_EN
      pass_q   <= pass_nxt;
`endif
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_nxt    = state;
    lfsr_nxt     = lfsr;
    sig_nxt      = sig_q;
    pat_cnt_nxt  = pat_cnt;
    init_cnt_nxt = init_cnt;
    vec_nxt      = vec_q;
`ifdef S27_BIST_CMP_EN
    pass_nxt     = pass_q;
`endif
    // x^8+x^6+x^5+x^4+1 Fibonacci step and CRC-16 (0x1021) signature step.
    lfsr_adv = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    sig_upd  = {sig_q[SIG_W-2:0], 1'b0} ^ ((sig_q[SIG_W-1] ^ G17) ? CRC_POLY : '0);

    case (state)
      S_IDLE, S_DONE: begin
        vec_nxt = '0;
        if (START) begin
          state_nxt    = S_INIT;
          sig_nxt      = '0;
          lfsr_nxt     = SEED_EFF;
          pat_cnt_nxt  = '0;
          init_cnt_nxt = '0;
          vec_nxt      = INIT_VEC;
`ifdef S27_BIST_CMP_EN
          pass_nxt     = 1'b0;
`endif
        end
      end
      S_INIT: begin
        vec_nxt = INIT_VEC;
        if (init_cnt == INIT_LAST) begin
          state_nxt = S_RUN;
          vec_nxt   = lfsr[VEC_W-1:0];
        end else begin
          init_cnt_nxt = init_cnt + INIT_W'(1);
        end
      end
      S_RUN: begin
        sig_nxt  = sig_upd;
        lfsr_nxt = lfsr_adv;
        vec_nxt  = lfsr_adv[VEC_W-1:0];
        // pat_cnt is the index of the current capture; it stops at the last one.
        if (pat_cnt == PAT_LAST) begin
          state_nxt = S_DONE;
          vec_nxt   = '0;
`ifdef S27_BIST_CMP_EN
          pass_nxt  = (sig_upd == EXP_SIG);
`endif
        end else begin
          pat_cnt_nxt = pat_cnt + PAT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        vec_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt == S_INIT) || (state_nxt == S_RUN);
    done_nxt = (state_nxt == S_DONE);
  end

  assign {G3, G2, G1, G0} = vec_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign SIG  = sig_q;
`ifdef S27_BIST_CMP_EN
  assign PASS = pass_q;
`else
  assign PASS = 1'b0;
`endif

endmodule
